// File: rtl/simon_input_encoder.sv
// Simon player input: sync, debounce, single-press encode, colour FIFO.
// Optional INPUT_TIMEOUT_EN adds an idle timeout pulse.
module simon_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       flush,
  input  logic [3:0] btn,
  output logic [1:0] color,
  output logic       color_valid,
  input  logic       color_ready,
  output logic [3:0] echo,
  output logic [3:0] count,
  output logic       overflow,
  output logic       multi_err,
  output logic       timeout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  function automatic logic [1:0] encode(input logic [3:0] oh);
    logic [1:0] c;
    c = 2'b00;
    unique case (1'b1)
      oh[0]:   c = 2'b00;
      oh[1]:   c = 2'b01;
      oh[2]:   c = 2'b10;
      oh[3]:   c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  logic [3:0] btn_m;
  logic [3:0] btn_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [3:0]    cand;
  logic [3:0]    cand_nx;
  logic          push;
  logic          multi_nx;
  logic [2:0]    ones;

  assign ones = 3'($countones(btn_s));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    push     = 1'b0;
    multi_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && ones == 3'd1) begin
          cand_nx  = btn_s;
          state_nx = S_DEBOUNCE;
          cnt_nx   = '0;
        end else if (enable && ones > 3'd1) begin
          multi_nx = 1'b1;
          state_nx = S_RELEASE;
          cnt_nx   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (btn_s != cand) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          push     = 1'b1;
          state_nx = S_HELD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (btn_s == 4'b0000) begin
          state_nx = S_RELEASE;
          cnt_nx   = '0;
        end
      end
      S_RELEASE: begin
        if (btn_s != 4'b0000) begin
          cnt_nx = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // flush parks in release so a held button is not counted twice
    if (flush) begin
      state_nx = S_RELEASE;
      cnt_nx   = '0;
      push     = 1'b0;
      multi_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cand      <= '0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cand      <= cand_nx;
      multi_err <= multi_nx;
    end
  end

  assign echo = (state == S_HELD) ? cand : 4'b0000;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full        = (occ == OCC_FULL);
  assign color_valid = (occ != '0);
  assign color       = mem[rd_ptr];
  assign pop         = color_valid && color_ready;
  assign push_ok     = push && (!full || pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 2'b00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) begin
        mem[wr_ptr] <= encode(cand);
        wr_ptr      <= wr_ptr + 1'b1;
        if (count != 4'hF) count <= count + 1'b1;
      end
      if (push && !push_ok) overflow <= 1'b1;
      unique case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_run;

  assign idle_run = enable && (state == S_IDLE) &&
                    (btn_s == 4'b0000) && !color_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (flush || !idle_run) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (idle_cnt == IDLE_LAST) begin
      idle_cnt <= '0;
      timeout  <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
      timeout  <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_simon_input_encoder.sv
// Bench for simon_input_encoder: directed scenarios plus random
// button traffic checked every cycle against a behavioural model.
module tb_simon_input_encoder;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       color_ready = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [1:0] color;
  logic       color_valid;
  logic [3:0] echo;
  logic [3:0] count;
  logic       overflow;
  logic       multi_err;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  simon_input_encoder #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .flush(flush),
    .btn(btn),
    .color(color),
    .color_valid(color_valid),
    .color_ready(color_ready),
    .echo(echo),
    .count(count),
    .overflow(overflow),
    .multi_err(multi_err),
    .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] code_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'b00;
  endfunction

  // Player model: waiting / confirming / holding / quieting phases,
  // each tracked by a run-length of qualifying synchronized samples.
  localparam int WAIT = 0, CONFIRM = 1, HOLD = 2, QUIET = 3;

  int         phase;
  int         streak;
  logic [3:0] pick;
  logic [3:0] s1, s2;
  logic [1:0] q[$];
  int         m_count;
  bit         m_ovf;
  bit         m_multi;
  logic [3:0] bs;
  bit         accept;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase = WAIT; streak = 0; pick = 0; s1 = 0; s2 = 0;
      q.delete(); m_count = 0; m_ovf = 0; m_multi = 0;
    end else begin
      bs = s2;
      m_multi = 0;
      accept = (phase == CONFIRM) && (bs == pick) && (streak + 1 == D);
      if (flush) begin
        q.delete(); m_count = 0; m_ovf = 0;
        phase = QUIET; streak = 0;
      end else begin
        if (q.size() > 0 && color_ready) void'(q.pop_front());
        if (accept) begin
          if (q.size() < DEPTH) begin
            q.push_back(code_of(pick));
            if (m_count < 15) m_count++;
          end else m_ovf = 1;
        end
        case (phase)
          WAIT: if (enable && $countones(bs) == 1) begin
            pick = bs; phase = CONFIRM; streak = 0;
          end else if (enable && $countones(bs) > 1) begin
            m_multi = 1; phase = QUIET; streak = 0;
          end
          CONFIRM: if (bs != pick) begin
            phase = WAIT; streak = 0;
          end else if (accept) begin
            phase = HOLD; streak = 0;
          end else streak++;
          HOLD: if (bs == 0) begin phase = QUIET; streak = 0; end
          default: if (bs != 0) streak = 0;
            else if (streak + 1 == D) begin phase = WAIT; streak = 0; end
            else streak++;
        endcase
      end
      s2 = s1;
      s1 = btn;
    end
  end

  always @(negedge clk) begin
    if (resetn && chk_on) begin
      chk("valid", color_valid, q.size() > 0);
      if (q.size() > 0) chk("color", color, q[0]);
      chk("echo", echo, (phase == HOLD) ? pick : 4'b0000);
      chk("count", count, m_count);
      chk("overflow", overflow, m_ovf);
      chk("multi_err", multi_err, m_multi);
`ifndef INPUT_TIMEOUT_EN
      chk("timeout", timeout, 0);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step(10);
    btn = 4'b0000;
    step(8);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(6);
  endtask

  int hold;

  initial begin
    step(3);
    chk("rst_valid", color_valid, 0);
    chk("rst_color", color, 0);
    chk("rst_echo", echo, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_multi", multi_err, 0);
    chk("rst_timeout", timeout, 0);
    resetn = 1'b1;
    enable = 1'b1;
    chk_on = 1'b1;
    step(1);

    // press latency: push lands on the sixth edge after the press
    btn = 4'b0100;
    repeat (6) @(posedge clk);
    #1 chk("t1_before_e6", color_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid", color_valid, 1);
    chk("t1_color", color, 2'b10);
    chk("t1_count", count, 1);
    chk("t1_echo", echo, 4'b0100);
    step(6);
    btn = 4'b0000;
    step(8);
    press(4'b0001);
    chk("t1_count2", count, 2);
    chk("t1_head", color, 2'b10);

    do_flush();
    btn = 4'b0010; step(2);
    btn = 4'b0000; step(1);
    btn = 4'b0010; step(10);
    btn = 4'b0000; step(8);
    chk("t2_count", count, 1);
    chk("t2_color", color, 2'b01);

    do_flush();
    btn = 4'b1001; step(3);
    btn = 4'b0000; step(1);
    btn = 4'b0001; step(6);
    btn = 4'b0000; step(8);
    chk("t3_ignored", count, 0);
    press(4'b0001);
    chk("t3_count", count, 1);
    chk("t3_color", color, 2'b00);

    do_flush();
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    press(4'b0001);
    chk("t4_count", count, 4);
    chk("t4_ovf", overflow, 1);
    color_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_pop", color, i);
      step(1);
    end
    chk("t4_empty", color_valid, 0);
    color_ready = 1'b0;

    press(4'b0010);
    press(4'b0010);
    press(4'b0010);
    press(4'b0010);
    press(4'b0010);
    chk("t5_ovf_pre", overflow, 1);
    do_flush();
    btn = 4'b1000;
    step(10);
    flush = 1'b1; step(1); flush = 1'b0;
    chk("t5_valid", color_valid, 0);
    chk("t5_ovf", overflow, 0);
    step(6);
    chk("t5_norepush", count, 0);
    btn = 4'b0000; step(8);
    press(4'b1000);
    chk("t5_color", color, 2'b11);
    chk("t5_count", count, 1);

    do_flush();
    btn = 4'b0001;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("rst_mid_valid", color_valid, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_echo", echo, 0);
    btn = 4'b0000;
    step(2);
    resetn = 1'b1;
    step(8);
    chk("rst_mid_nopush", color_valid, 0);

    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: btn = 4'b0000;
          8, 9: begin
            btn = 4'($urandom_range(0, 15));
            while ($countones(btn) < 2) btn = 4'($urandom_range(0, 15));
          end
          default: btn = 4'b0001 << $urandom_range(0, 3);
        endcase
        hold = $urandom_range(1, 12);
      end
      hold--;
      enable = ($urandom_range(0, 9) != 0);
      color_ready = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 149) == 0);
      step(1);
    end
    flush = 1'b0;
    btn = 4'b0000;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_input_encoder.md
Name: simon_input_encoder

Overview:
Player-side input capture for the Simon game, working in the opposite direction to the pattern display path. It converts the four raw colour buttons into debounced, single-press 2-bit colour codes. Codes use the same encoding as the colour display: B=00, G=01, R=10, Y=11. Codes are queued in a small FIFO and handed to the compare stage over a valid/ready handshake; the block also reports press count and error flags to the game controller.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (>=2)
FIFO_DEPTH, 4, colour queue entries, power of 2, 2..16
TIMEOUT_CYCLES, 1023, idle cycles before timeout pulse (optional feature only)

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
enable  in  1  high = new presses may start (compare phase)
flush  in  1  synchronous clear of queue, count, overflow
btn  in  4  raw buttons, active-high; [0]=B [1]=G [2]=R [3]=Y
color  out  2  FIFO head colour code
color_valid  out  1  FIFO non-empty
color_ready  in  1  consumer accepts head this cycle
echo  out  4  one-hot of the accepted button while it is held
count  out  4  presses accepted since reset/flush, saturates at 15
overflow  out  1  sticky, a press was dropped because the FIFO was full
multi_err  out  1  one-cycle pulse, more than one button pressed
timeout  out  1  one-cycle pulse, player idle too long (optional)

Behaviour:
- Reset (async, resetn=0): sync regs=0, FSM=S_IDLE, FIFO empty, color=00, color_valid=0, echo=0, count=0, overflow=0, multi_err=0, timeout=0.
- btn passes through a 2-FF synchronizer to form btn_s; everything below uses btn_s.
- FSM states: S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE. A debounce counter cnt is cleared on every state entry.
- S_IDLE: if enable=1 and btn_s has exactly one bit set -> latch cand=btn_s, go to S_DEBOUNCE. If enable=1 and btn_s has >=2 bits set -> pulse multi_err, go to S_RELEASE. If enable=0 -> stay.
- S_DEBOUNCE: if btn_s!=cand -> S_IDLE, no push (bounce rejected). Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> push encode(cand), go to S_HELD; else cnt++. enable dropping does not abort an in-flight press.
- S_HELD: echo=cand (echo=0 in all other states). When btn_s==0 -> S_RELEASE.
- S_RELEASE: if btn_s!=0 -> cnt=0. If btn_s==0 and cnt==DEBOUNCE_CYCLES-1 -> S_IDLE; else cnt++.
- Press latency: raw press stable before edge E0 -> btn_s valid after E1 -> S_DEBOUNCE after E2 -> push on edge E(2+DEBOUNCE_CYCLES) -> color_valid=1 immediately after that edge.
- FIFO:
  - color = head entry (combinational); color_valid = !empty.
  - Pop on color_valid && color_ready.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - An accepted push increments count (saturating at 15).
  - A rejected push sets overflow and leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; a separate occupancy counter distinguishes full from empty.
- flush (highest synchronous priority):
  - Empties the FIFO; count=0, overflow=0.
  - Any push in the same cycle is discarded.
  - FSM forced to S_RELEASE, so a button still held is not re-registered.
- Simultaneous multi-press during S_DEBOUNCE counts as btn_s!=cand -> S_IDLE. The next S_IDLE cycle then flags multi_err.
- Async reset mid-operation discards the in-flight press and all queued codes.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined: an idle counter runs while enable=1, FSM=S_IDLE, btn_s==0 and the FIFO is empty; it is cleared otherwise and on flush. When the counter equals TIMEOUT_CYCLES-1, timeout pulses for one cycle and the counter restarts at 0.
- Undefined: timeout is tied to 0, no counter logic exists, and TIMEOUT_CYCLES is unused.

Test Plan:
1. DEBOUNCE_CYCLES=4, enable=1, color_ready=0; btn=0100 stable from E0 for 12 cycles -> color_valid=1 after E6 with color=10, echo=0100 while held, count=1; release then btn=0001 -> second push, color stays 10 (head).
2. btn=0010 for 2 cycles, 0000 for 1 cycle, then 0010 for 10 cycles -> exactly one push (color=01, count=1), no multi_err.
3. btn=1001 -> multi_err one-cycle pulse, no push, count=0; btn=0001 applied before 4 clean release cycles -> ignored; after release -> accepted, color=00.
4. color_ready=0, press B,G,R,Y,B -> FIFO holds 00,01,10,11; 5th press dropped, overflow=1, count=4; then color_ready=1 -> 00,01,10,11 pop on consecutive cycles, then color_valid=0.
5. Hold btn=1000 until accepted, pulse flush while still held -> color_valid=0, count=0, overflow=0, no re-push; release, press 1000 again -> pushed, color=11, count=1.
6. INPUT_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, enable=1, no buttons -> timeout pulses every 16 cycles; any press before the 16th cycle clears the counter, no pulse. Also: resetn=0 mid-S_DEBOUNCE -> all outputs reset immediately, no push.
